ifetch_ctrl: RTL and testbench

Instruction fetch controller that sequences the 16-word instruction memory for the core. It owns the program counter, drives the memory's 16-bit `pc` input, and captures the combinational 16-bit `instruction` into a 2-entry prefetch queue. Decode consumes the queue through a valid/ready handshake. Execute redirects the counter on branches and jumps.

---
 rtl/ifetch_ctrl.sv | 126 ++++++++++++
 tb/tb_ifetch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the PC, fills a 2-entry prefetch queue, serves decode.
// Define IFETCH_MISALIGN_CHK_EN to trap odd redirect targets in a sticky ERR state.
module ifetch_ctrl #(
   parameter int unsigned     PC_W     = 16,
   parameter int unsigned     INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
   parameter logic [PC_W-1:0] LAST_PC  = 16'h001C
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [PC_W-1:0]    imem_pc,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               fetch_done,
   output logic               fetch_err
);

`ifdef IFETCH_MISALIGN_CHK_EN
   typedef enum logic [1:0] {S_RUN, S_DONE, S_ERR} state_e;
`else
   typedef enum logic [1:0] {S_RUN, S_DONE} state_e;
`endif

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d, pc_inc, redir_tgt;
   logic [1:0]          cnt_q, cnt_d, cnt_mid;
   logic [INSTR_W-1:0]  h_instr_q, h_instr_d, t_instr_q, t_instr_d;
   logic [PC_W-1:0]     h_pc_q, h_pc_d, t_pc_q, t_pc_d;
   logic                pop, fetch, redir_hit, redir_bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RUN;
         pc_q      <= RESET_PC;
         cnt_q     <= '0;
         h_instr_q <= '0;
         h_pc_q    <= '0;
         t_instr_q <= '0;
         t_pc_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         h_instr_q <= h_instr_d;
         h_pc_q    <= h_pc_d;
         t_instr_q <= t_instr_d;
         t_pc_q    <= t_pc_d;
      end
   end

   always_comb begin
      pop    = (cnt_q != 2'd0) && out_ready;
      pc_inc = pc_q + PC_W'(2);
`ifdef IFETCH_MISALIGN_CHK_EN
      redir_hit = redirect_valid && (state_q != S_ERR);
      redir_bad = redir_hit && redirect_pc[0];
      redir_tgt = redirect_pc;
`else
      redir_hit = redirect_valid;
      redir_bad = 1'b0;
      redir_tgt = redirect_pc & ~PC_W'(1);
`endif
      fetch = (state_q == S_RUN) && !redirect_valid && ((cnt_q != 2'd2) || pop);

      state_d   = state_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      h_instr_d = h_instr_q;
      h_pc_d    = h_pc_q;
      t_instr_d = t_instr_q;
      t_pc_d    = t_pc_q;
      cnt_mid   = cnt_q - {1'b0, pop};

      if (redir_hit) begin
         cnt_d = '0;
`ifdef IFETCH_MISALIGN_CHK_EN
         if (redir_bad) begin
            state_d = S_ERR;
         end else
`endif
         begin
            pc_d    = redir_tgt;
            state_d = (redir_tgt > LAST_PC) ? S_DONE : S_RUN;
         end
      end else begin
         if (pop) begin
            h_instr_d = t_instr_q;
            h_pc_d    = t_pc_q;
         end
         // New word lands at whichever slot is first free after the pop
         if (fetch) begin
            if (cnt_mid == 2'd0) begin
               h_instr_d = imem_instr;
               h_pc_d    = pc_q;
            end else begin
               t_instr_d = imem_instr;
               t_pc_d    = pc_q;
            end
            cnt_d = cnt_mid + 2'd1;
            pc_d  = pc_inc;
            if (pc_inc > LAST_PC) state_d = S_DONE;
         end else begin
            cnt_d = cnt_mid;
         end
      end
   end

   always_comb begin
      imem_pc    = pc_q;
      out_valid  = (cnt_q != 2'd0);
      out_instr  = h_instr_q;
      out_pc     = h_pc_q;
      fetch_done = (state_q == S_DONE);
`ifdef IFETCH_MISALIGN_CHK_EN
      fetch_err  = (state_q == S_ERR);
`else
      fetch_err  = 1'b0;
`endif
   end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus randomized run against a queue model.
module tb_ifetch_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] imem_pc, imem_instr, out_instr, out_pc, redirect_pc;
   logic        out_valid, out_ready, redirect_valid, fetch_done, fetch_err;
   logic [15:0] mem [16];
   int          errors = 0;
   int          checks = 0;

   typedef struct packed { logic [15:0] instr; logic [15:0] pc; } ent_t;

   ifetch_ctrl #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000), .LAST_PC(16'h001C)) dut (
      .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fetch_done(fetch_done), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;
   assign imem_instr = mem[imem_pc[4:1]];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic ready);
      rst_n = 1'b0;
      out_ready = ready;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(1'b1);
      rst_n = 1'b0;
      #1;
      checks++; if (imem_pc !== 16'h0000) begin errors++; $display("FAIL reset_imem_pc: got %h want 0000", imem_pc); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_instr !== 16'h0000) begin errors++; $display("FAIL reset_out_instr: got %h want 0000", out_instr); end
      checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL reset_out_pc: got %h want 0000", out_pc); end
      checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL reset_fetch_done: got %b want 0", fetch_done); end
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err: got %b want 0", fetch_err); end
   endtask

   task automatic test_stream();
      do_reset(1'b1);
      tick();
      for (int i = 0; i < 15; i++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
         checks++; if (out_pc !== 16'(2 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, out_pc, 16'(2 * i)); end
         checks++; if (out_instr !== mem[i]) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, mem[i]); end
         checks++; if (fetch_done !== (i == 14)) begin errors++; $display("FAIL stream_done[%0d]: got %b want %b", i, fetch_done, i == 14); end
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b want 0", out_valid); end
      checks++; if (fetch_done !== 1'b1) begin errors++; $display("FAIL stream_final_done: got %b want 1", fetch_done); end
   endtask

   task automatic test_backpressure();
      do_reset(1'b0);
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_instr !== mem[0]) begin
            errors++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h i=%h want v=1 pc=0000 i=%h", c, out_valid, out_pc, out_instr, mem[0]);
         end
      end
      checks++; if (imem_pc !== 16'h0004) begin errors++; $display("FAIL bp_imem_pc: got %h want 0004", imem_pc); end
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         checks++; if (out_valid !== 1'b1 || out_pc !== 16'(2 * j)) begin
            errors++; $display("FAIL bp_release[%0d]: got v=%b pc=%h want v=1 pc=%h", j, out_valid, out_pc, 16'(2 * j));
         end
         tick();
      end
   endtask

   task automatic test_redirect_flush();
      do_reset(1'b0);
      tick();
      tick();
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      checks++; if (out_pc !== 16'h0004 || imem_pc !== 16'h0008) begin
         errors++; $display("FAIL flush_setup: got pc=%h imem=%h want pc=0004 imem=0008", out_pc, imem_pc);
      end
      redirect_valid = 1'b1;
      redirect_pc = 16'h000A;
      tick();
      redirect_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      checks++; if (imem_pc !== 16'h000A) begin errors++; $display("FAIL flush_imem_pc: got %h want 000A", imem_pc); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 16'h000A || out_instr !== mem[5]) begin
         errors++; $display("FAIL flush_target: got v=%b pc=%h i=%h want v=1 pc=000A i=%h", out_valid, out_pc, out_instr, mem[5]);
      end
      out_ready = 1'b1;
      tick();
      checks++; if (out_pc !== 16'h000C) begin errors++; $display("FAIL flush_next: got %h want 000C", out_pc); end
   endtask

   task automatic test_redirect_handshake();
      do_reset(1'b1);
      tick();
      tick();
      checks++; if (out_pc !== 16'h0002 || out_valid !== 1'b1) begin
         errors++; $display("FAIL hs_setup: got v=%b pc=%h want v=1 pc=0002", out_valid, out_pc);
      end
      redirect_valid = 1'b1;
      redirect_pc = 16'h0010;
      tick();
      redirect_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hs_bubble: got %b want 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0010) begin
         errors++; $display("FAIL hs_target: got v=%b pc=%h want v=1 pc=0010", out_valid, out_pc);
      end
      tick();
      checks++; if (out_pc !== 16'h0012) begin errors++; $display("FAIL hs_follow: got %h want 0012", out_pc); end
   endtask

   task automatic test_done_redirect();
      do_reset(1'b1);
      for (int i = 0; i < 17; i++) tick();
      checks++; if (fetch_done !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL done_setup: got done=%b v=%b want done=1 v=0", fetch_done, out_valid);
      end
      redirect_valid = 1'b1;
      redirect_pc = 16'h0010;
      tick();
      redirect_valid = 1'b0;
      checks++; if (fetch_done !== 1'b0 || imem_pc !== 16'h0010) begin
         errors++; $display("FAIL done_resume: got done=%b imem=%h want done=0 imem=0010", fetch_done, imem_pc);
      end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0010 || out_instr !== mem[8]) begin
         errors++; $display("FAIL done_resume_out: got v=%b pc=%h i=%h want v=1 pc=0010 i=%h", out_valid, out_pc, out_instr, mem[8]);
      end
      redirect_valid = 1'b1;
      redirect_pc = 16'h0020;
      tick();
      redirect_valid = 1'b0;
      checks++; if (fetch_done !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL done_past_end: got done=%b v=%b want done=1 v=0", fetch_done, out_valid);
      end
      tick();
      checks++; if (imem_pc !== 16'h0020 || out_valid !== 1'b0) begin
         errors++; $display("FAIL done_no_fetch: got imem=%h v=%b want imem=0020 v=0", imem_pc, out_valid);
      end
   endtask

   task automatic test_misalign();
      do_reset(1'b1);
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 16'h0005;
      tick();
      redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
      checks++; if (fetch_err !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL mis_err: got err=%b v=%b want err=1 v=0", fetch_err, out_valid);
      end
      redirect_valid = 1'b1;
      redirect_pc = 16'h0000;
      tick();
      redirect_valid = 1'b0;
      tick();
      checks++; if (fetch_err !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL mis_sticky: got err=%b v=%b want err=1 v=0", fetch_err, out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", fetch_err); end
      rst_n = 1'b1;
`else
      checks++; if (out_valid !== 1'b0 || imem_pc !== 16'h0004) begin
         errors++; $display("FAIL mis_force: got v=%b imem=%h want v=0 imem=0004", out_valid, imem_pc);
      end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0004 || fetch_err !== 1'b0) begin
         errors++; $display("FAIL mis_deliver: got v=%b pc=%h err=%b want v=1 pc=0004 err=0", out_valid, out_pc, fetch_err);
      end
`endif
   endtask

   task automatic test_async_reset();
      do_reset(1'b1);
      for (int i = 0; i < 6; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (imem_pc !== 16'h0000 || out_valid !== 1'b0 || out_pc !== 16'h0000 || out_instr !== 16'h0000 || fetch_done !== 1'b0) begin
         errors++; $display("FAIL async_reset: got imem=%h v=%b pc=%h i=%h done=%b want 0000/0/0000/0000/0", imem_pc, out_valid, out_pc, out_instr, fetch_done);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      ent_t  mq[$];
      int    m_pc = 0;
      bit    m_done = 0;
      bit    m_err = 0;
      bit    rdy, rv, popped;
      int    tgt;
      do_reset(1'b0);
      for (int c = 0; c < 600; c++) begin
         checks++; if (imem_pc !== 16'(m_pc)) begin errors++; $display("FAIL rnd_imem_pc[%0d]: got %h want %h", c, imem_pc, 16'(m_pc)); end
         checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, mq.size() > 0); end
         if (mq.size() > 0) begin
            checks++; if (out_pc !== mq[0].pc || out_instr !== mq[0].instr) begin
               errors++; $display("FAIL rnd_head[%0d]: got pc=%h i=%h want pc=%h i=%h", c, out_pc, out_instr, mq[0].pc, mq[0].instr);
            end
         end
         checks++; if (fetch_done !== m_done || fetch_err !== m_err) begin
            errors++; $display("FAIL rnd_flags[%0d]: got done=%b err=%b want done=%b err=%b", c, fetch_done, fetch_err, m_done, m_err);
         end
         rdy = ($urandom_range(0, 9) < 7);
         rv  = ($urandom_range(0, 11) == 0);
`ifdef IFETCH_MISALIGN_CHK_EN
         tgt = 2 * $urandom_range(0, 17);
`else
         tgt = $urandom_range(0, 35);
`endif
         out_ready = rdy;
         redirect_valid = rv;
         redirect_pc = 16'(tgt);
         popped = rdy && (mq.size() > 0);
         if (popped) void'(mq.pop_front());
         if (rv && !m_err) begin
            mq.delete();
            if (tgt % 2 == 1 && `ifdef IFETCH_MISALIGN_CHK_EN 1 `else 0 `endif) m_err = 1;
            else begin
               m_pc = tgt - (tgt % 2);
               m_done = (m_pc > 28);
            end
         end else if (!rv && !m_done && !m_err && mq.size() < 2) begin
            mq.push_back({mem[(m_pc / 2) % 16], 16'(m_pc)});
            m_pc = m_pc + 2;
            if (m_pc > 28) m_done = 1;
         end
         tick();
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      out_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_flush();
      test_redirect_handshake();
      test_done_redirect();
      test_misalign();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
